// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   op_e    - operation encoding carried on the request bus
//   state_e - sequencer states (IDLE, RUN, FIX, DONE)
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,  // signed multiply
    OP_MULU = 2'b01,  // unsigned multiply
    OP_DIV  = 2'b10,  // signed divide
    OP_DIVU = 2'b11   // unsigned divide
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bus of the multiply/divide unit.
//   start, op, a, b        - request (a/b are MSB-first: bit 0 = MSB)
//   busy, done             - status (busy in RUN/FIX, done one cycle in DONE)
//   result_hi, result_lo   - product halves, or remainder / quotient
//   div_by_zero            - divide had a zero divisor
// master: requester side; slave: the unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  import muldiv_pkg::*;

  logic             start;
  op_e              op;
  logic [0:WIDTH-1] a;
  logic [0:WIDTH-1] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_hi, result_lo, div_by_zero
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the iterative multiply/divide unit.
//   clk, reset - clock, async active-high reset
//   start      - request strobe (only honoured in IDLE or DONE)
//   busy       - high in RUN and FIX
//   done       - high in DONE (single cycle unless followed by DONE again, which cannot happen)
//   accept     - request taken this edge: datapath loads operands
//   step_en    - one radix-2 iteration this edge
//   fix_en     - sign-correction edge
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH+1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic accept,
  output logic step_en,
  output logic fix_en
);

  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(1);

  state_e          state, state_nxt;
  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)       cnt <= CNT_LOAD;
      else if (step_en) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    step_en   = 1'b0;
    fix_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        step_en = 1'b1;
        // last iteration happens on the edge that takes cnt 1 -> 0
        if (cnt == CNT_LAST) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        fix_en    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // back-to-back: accept straight from DONE, no IDLE bubble
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide, signed and
// unsigned, WIDTH steps plus one sign-fix edge.
//   clk, reset - clock, async active-high reset
//   bus        - muldiv_unit_if slave (request, status, results)
// Datapath works on magnitudes; signs are reapplied on the FIX edge.
// acc holds product-high / remainder, q holds multiplier->product-low /
// dividend->quotient; both feed the result outputs directly.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH+1)
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);

  logic busy, done, accept, step_en, fix_en;

  muldiv_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start   (bus.start),
    .busy    (busy),
    .done    (done),
    .accept  (accept),
    .step_en (step_en),
    .fix_en  (fix_en)
  );

  // ---- request decode (only meaningful on the accept edge)
  logic [WIDTH-1:0] a_v, b_v, a_mag, b_mag;
  logic             is_div, a_neg, b_neg, dz_in;

  assign a_v    = bus.a;  // MSB-first port; numeric value unchanged
  assign b_v    = bus.b;
  assign is_div = op_is_div(bus.op);
  assign a_neg  = op_is_signed(bus.op) & a_v[WIDTH-1];
  assign b_neg  = op_is_signed(bus.op) & b_v[WIDTH-1];
  assign dz_in  = is_div & (b_v == '0);
  // Zero divisor: keep the raw dividend so the remainder comes out as a
  // unchanged and no sign fix is applied.
  assign a_mag  = (a_neg & ~dz_in) ? -a_v : a_v;
  assign b_mag  = b_neg ? -b_v : b_v;

  // ---- working state
  logic [WIDTH-1:0] acc, q, m;
  logic             div_r, neg_lo, neg_hi, dz_pend, dz_out;

  // ---- shared WIDTH+1-bit adder/subtractor
  // mul: {0,acc} + (q[0] ? m : 0); div: {acc,q[msb]} - m
  logic [WIDTH:0] add_x, add_y, add_s;

  assign add_x = div_r ? {acc, q[WIDTH-1]} : {1'b0, acc};
  assign add_y = {1'b0, m & {WIDTH{div_r | q[0]}}};
  assign add_s = add_x + (add_y ^ {(WIDTH+1){div_r}}) + (WIDTH+1)'(div_r);

  // Remainder stays below m, so bit WIDTH of the difference is a clean
  // "went negative" flag for the restoring step.
  logic [2*WIDTH-1:0] prod_neg;
  assign prod_neg = -{acc, q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      div_r   <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      dz_pend <= 1'b0;
      dz_out  <= 1'b0;
    end else if (accept) begin
      acc     <= '0;
      q       <= a_mag;
      m       <= b_mag;
      div_r   <= is_div;
      neg_lo  <= ~dz_in & (a_neg ^ b_neg);
      neg_hi  <= is_div ? (~dz_in & a_neg) : 1'b0;
      dz_pend <= dz_in;
      dz_out  <= 1'b0;
    end else if (step_en) begin
      if (!div_r) begin
        acc <= add_s[WIDTH:1];
        q   <= {add_s[0], q[WIDTH-1:1]};
      end else if (add_s[WIDTH]) begin
        acc <= add_x[WIDTH-1:0];  // restore
        q   <= {q[WIDTH-2:0], 1'b0};
      end else begin
        acc <= add_s[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], 1'b1};
      end
    end else if (fix_en) begin
      if (!div_r) begin
        if (neg_lo) {acc, q} <= prod_neg;
      end else begin
        if (neg_lo) q   <= -q;
        if (neg_hi) acc <= -acc;
      end
      dz_out <= dz_pend;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.result_hi   = acc;
  assign bus.result_lo   = q;
  assign bus.div_by_zero = dz_out;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Issue one request, return edges-to-done, busy cycle count and the
  // div_by_zero value right after the accept edge. Bounded at 60 edges.
  task automatic run_op(input op_e o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int bcnt, output logic dz_acc);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dz_acc = bus.div_by_zero;
    lat = 0;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", bus.div_by_zero); end
    checks++; if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.result_lo); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mulu_max();
    int lat, bcnt; logic dz;
    run_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mulu_latency got %0d want 33", lat); end
    checks++; if (bcnt !== 33) begin errors++; $display("FAIL mulu_busy_cycles got %0d want 33", bcnt); end
    checks++; if (bus.result_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulu_hi got %h want fffffffe", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'h00000001) begin errors++; $display("FAIL mulu_lo got %h want 00000001", bus.result_lo); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL mulu_dz got %b want 0", bus.div_by_zero); end
    // done is a single-cycle pulse; results hold afterwards
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", bus.done); end
    checks++; if (bus.result_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL hold_hi got %h want fffffffe", bus.result_hi); end
  endtask

  task automatic test_mul_signed();
    int lat, bcnt; logic dz;
    run_op(OP_MUL, 32'hFFFFFFFD, 32'd5, lat, bcnt, dz);  // -3 * 5 = -15
    checks++; if (bus.result_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mul_neg_hi got %h want ffffffff", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mul_neg_lo got %h want fffffff1", bus.result_lo); end
    run_op(OP_MUL, 32'hFFFFFFFC, 32'hFFFFFFF8, lat, bcnt, dz);  // -4 * -8 = 32
    checks++; if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL mul_pos_hi got %h want 0", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'h20) begin errors++; $display("FAIL mul_pos_lo got %h want 20", bus.result_lo); end
  endtask

  task automatic test_div_signed();
    int lat, bcnt; logic dz;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bcnt, dz);  // -7 / 2 = -3 r -1
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
    checks++; if (bus.result_lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_q got %h want fffffffd", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_r got %h want ffffffff", bus.result_hi); end
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, bcnt, dz);  // 7 / -2 = -3 r 1
    checks++; if (bus.result_lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_q got %h want fffffffd", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'h1) begin errors++; $display("FAIL div_negb_r got %h want 1", bus.result_hi); end
  endtask

  task automatic test_div_zero();
    int lat, bcnt; logic dz;
    run_op(OP_DIVU, 32'd100, 32'd0, lat, bcnt, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL dz_latency got %0d want 33", lat); end
    checks++; if (bus.result_lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_q got %h want ffffffff", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'd100) begin errors++; $display("FAIL divu0_r got %h want 64", bus.result_hi); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL divu0_flag got %b want 1", bus.div_by_zero); end
    run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, lat, bcnt, dz);  // signed -5 / 0
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL dz_clear_on_accept got %b want 0", dz); end
    checks++; if (bus.result_lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_q got %h want ffffffff", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'hFFFFFFFB) begin errors++; $display("FAIL div0_r got %h want fffffffb", bus.result_hi); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL div0_flag got %b want 1", bus.div_by_zero); end
  endtask

  task automatic test_div_overflow();
    int lat, bcnt; logic dz;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, dz);
    checks++; if (bus.result_lo !== 32'h80000000) begin errors++; $display("FAIL ovf_q got %h want 80000000", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL ovf_r got %h want 0", bus.result_hi); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dz got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULU; bus.a = 32'd3; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat++;
    while (!bus.done && lat < 60) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", lat); end
    checks++; if (bus.result_lo !== 32'd14) begin errors++; $display("FAIL ignore_q got %h want e", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'd2) begin errors++; $display("FAIL ignore_r got %h want 2", bus.result_hi); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic dz;
    run_op(OP_MULU, 32'd1000, 32'd1000, lat, bcnt, dz);
    checks++; if (bus.result_lo !== 32'd1000000) begin errors++; $display("FAIL b2b_first got %h want f4240", bus.result_lo); end
    // issued while done is high: must start without passing through IDLE
    run_op(OP_DIVU, 32'd1000, 32'd3, lat, bcnt, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    checks++; if (bcnt !== 33) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 33", bcnt); end
    checks++; if (bus.result_lo !== 32'd333) begin errors++; $display("FAIL b2b_q got %h want 14d", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'd1) begin errors++; $display("FAIL b2b_r got %h want 1", bus.result_hi); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, seen; logic dz;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULU; bus.a = 32'hFFFFFFFF; bus.b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    checks++; if (bus.result_hi !== 32'h0) begin errors++; $display("FAIL midrst_hi got %h want 0", bus.result_hi); end
    checks++; if (bus.result_lo !== 32'h0) begin errors++; $display("FAIL midrst_lo got %h want 0", bus.result_lo); end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (bus.done) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", seen); end
    run_op(OP_MULU, 32'd6, 32'd7, lat, bcnt, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL post_rst_latency got %0d want 33", lat); end
    checks++; if (bus.result_lo !== 32'd42) begin errors++; $display("FAIL post_rst_lo got %h want 2a", bus.result_lo); end
    checks++; if (bus.result_hi !== 32'd0) begin errors++; $display("FAIL post_rst_hi got %h want 0", bus.result_hi); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = OP_MUL; bus.a = '0; bus.b = '0;
    test_reset();
    test_mulu_max();
    test_mul_signed();
    test_div_signed();
    test_div_zero();
    test_div_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have parameter: CNTW, $clog2(WIDTH+1), iteration-counter width (derived; not overridden).
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request; accepted only in IDLE or DONE.
REQ-006 SHALL have port: op  input  2  00 mul signed, 01 mulu, 10 div signed, 11 divu; sampled with start.
REQ-007 SHALL have port: a  input  WIDTH  multiplicand/dividend, bit 0 = MSB ([0:WIDTH-1]); sampled with start.
REQ-008 SHALL have port: b  input  WIDTH  multiplier/divisor, bit 0 = MSB; sampled with start.
REQ-009 SHALL have port: busy  output  1  high in RUN and FIX; drives pipeline stall.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, high only in DONE.
REQ-011 SHALL have port: result_hi  output  WIDTH  product upper half, or remainder.
REQ-012 SHALL have port: result_lo  output  WIDTH  product lower half, or quotient.
REQ-013 SHALL have port: div_by_zero  output  1  high with done when a div/divu had b == 0.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-015 Transitions: IDLE -start-> RUN; RUN -counter expires-> FIX; FIX -> DONE; DONE -start-> RUN, else -> IDLE.
REQ-016 Accept edge k SHALL latch op, operand magnitudes (signed ops), result sign flags, and load counter with WIDTH.
REQ-017 RUN SHALL do one radix-2 step per edge: shift-add for multiply, restoring subtract-shift for divide; WIDTH steps total.
REQ-018 FIX edge SHALL two's-complement-negate per latched sign flags; done SHALL be high in the cycle after edge k+WIDTH+1.
REQ-019 Signed sign rules: product negative iff operand signs differ; quotient negative iff signs differ; remainder takes dividend's sign.
REQ-020 Multiply SHALL produce the exact 2*WIDTH-bit product split as result_hi:result_lo.
REQ-021 Division by zero SHALL give quotient all-ones, remainder = a, div_by_zero = 1, with the same latency.
REQ-022 Signed overflow (a = most-negative, b = -1) SHALL give quotient = a, remainder 0, div_by_zero 0.
REQ-023 start while busy SHALL be ignored, with no effect on state or results.
REQ-024 Results SHALL hold their values from DONE until the next accept edge; they are invalid while busy.
REQ-025 Back-to-back: start in DONE SHALL be accepted on that edge with no IDLE bubble.
REQ-026 div_by_zero SHALL clear on the next accept edge.

Reset
REQ-027 Assertion of reset SHALL immediately force IDLE, counter 0, and busy, done, div_by_zero, result_hi and result_lo to 0.
REQ-028 Reset mid-operation SHALL abandon the operation without producing a done pulse.
REQ-029 First start after reset deassertion SHALL be accepted normally.

Structure
REQ-030 Shared package muldiv_pkg SHALL hold the op encodings (OP_MUL, OP_MULU, OP_DIV, OP_DIVU) and the state enumeration.
REQ-031 FSM plus counter SHALL be one sub-module, muldiv_ctrl (outputs busy, done, step enable, fix enable); the datapath stays in muldiv_unit.
REQ-032 The datapath SHALL use a single WIDTH+1-bit adder/subtractor shared by multiply and divide.

Verification (WIDTH=32)
REQ-033 mulu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at accept+33 edges, busy for 33 cycles.
REQ-034 mul a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 divu a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 start pulsed at RUN cycle 10 with different operands -> ignored, original result delivered; start in DONE -> next op accepted, no gap.
REQ-037 reset asserted at RUN cycle 15 -> all outputs 0 immediately, no done pulse; next mulu 6*7 -> lo=42, hi=0.
